// File: rtl/spec_mux_probe_pkg.sv
// Shared types and constants for probing the 4-input special mux:
// FSM state encoding, select width and the per-select expected-value table.
package spec_mux_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned NUM_SEL = 1 << SEL_W;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    EXP_ZERO,
    EXP_ONE,
    EXP_INP3
  } exp_t;

  // Index = select value; EXP_INP3 entries must match the sample taken at sel=2.
  localparam exp_t EXP_TABLE [NUM_SEL] = '{
    EXP_ZERO, EXP_ZERO, EXP_INP3, EXP_INP3,
    EXP_INP3, EXP_ZERO, EXP_ONE,  EXP_INP3
  };

  function automatic logic expected_bit(input exp_t e, input logic inp3);
    logic r;
    case (e)
      EXP_ZERO: r = 1'b0;
      EXP_ONE:  r = 1'b1;
      EXP_INP3: r = inp3;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spec_mux_probe_if.sv
// Handshake and mux-facing signals of the probe; master is the host side,
// slave is the probe itself.
interface spec_mux_probe_if;

  logic                               start;
  logic [spec_mux_pkg::SEL_W-1:0]     sel_out;
  logic                               mux_out;
  logic                               busy;
  logic                               done;
  logic                               bit3;
  logic                               err;
  logic [spec_mux_pkg::NUM_SEL-1:0]   err_mask;

  modport master (
    output start,
    output mux_out,
    input  sel_out,
    input  busy,
    input  done,
    input  bit3,
    input  err,
    input  err_mask
  );

  modport slave (
    input  start,
    input  mux_out,
    output sel_out,
    output busy,
    output done,
    output bit3,
    output err,
    output err_mask
  );

endinterface

// File: rtl/spec_mux.sv
// Existing 4-input special mux: selects 0,1,5 give 0, select 6 gives 1,
// selects 2,3,4,7 pass inp[3].
module spec_mux (
  input  logic [3:0] inp,
  input  logic [2:0] sel,
  output logic       y
);

  logic unused_inp;
  assign unused_inp = ^inp[2:0];

  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0, 3'd1, 3'd5: y = 1'b0;
      3'd6:             y = 1'b1;
      default:          y = inp[3];
    endcase
  end

endmodule

// File: rtl/spec_mux_probe.sv
// Sweeps all eight selects of the special mux, holding each for SETTLE cycles,
// recovers inp[3] and flags any select whose result disagrees with the table.
module spec_mux_probe
  import spec_mux_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  spec_mux_probe_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = '1;
  localparam logic [SEL_W-1:0] BIT3_SEL = SEL_W'(2);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 bit3_acc_q, bit3_acc_d;
  logic [NUM_SEL-1:0]   mask_acc_q, mask_acc_d;
  logic                 bit3_q, bit3_d;
  logic                 err_q, err_d;
  logic [NUM_SEL-1:0]   err_mask_q, err_mask_d;

  logic                 sample_now;
  logic                 smp_bit3;
  logic                 smp_exp;
  logic                 smp_miss;
  logic [NUM_SEL-1:0]   smp_mask;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample evaluation for the current hold; sel=2 supplies its own reference.
  always_comb begin
    sample_now = (state_q == S_SWEEP) && (cnt_q == LAST_CNT);
    smp_bit3   = (sel_q == BIT3_SEL) ? bus.mux_out : bit3_acc_q;
    smp_exp    = expected_bit(EXP_TABLE[sel_q], smp_bit3);
    smp_miss   = (bus.mux_out != smp_exp);
    smp_mask   = mask_acc_q | (NUM_SEL'(smp_miss) << sel_q);
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SWEEP;
      S_SWEEP: if (sample_now && (sel_q == LAST_SEL)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.sel_out  = sel_q;
    bus.busy     = (state_q == S_SWEEP);
    bus.done     = (state_q == S_DONE);
    bus.bit3     = bit3_q;
    bus.err      = err_q;
    bus.err_mask = err_mask_q;
  end

  // Counters and result accumulation
  always_comb begin
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    bit3_acc_d = bit3_acc_q;
    mask_acc_d = mask_acc_q;
    bit3_d     = bit3_q;
    err_d      = err_q;
    err_mask_d = err_mask_q;
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        sel_d      = '0;
        bit3_acc_d = 1'b0;
        mask_acc_d = '0;
      end
      S_SWEEP: begin
        if (sample_now) begin
          cnt_d      = '0;
          sel_d      = sel_q + SEL_W'(1);
          bit3_acc_d = smp_bit3;
          mask_acc_d = smp_mask;
          // Published results are loaded only on the final sample, i.e. on DONE entry.
          if (sel_q == LAST_SEL) begin
            bit3_d     = smp_bit3;
            err_mask_d = smp_mask;
            err_d      = |smp_mask;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      bit3_acc_q <= 1'b0;
      mask_acc_q <= '0;
      bit3_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      bit3_acc_q <= bit3_acc_d;
      mask_acc_q <= mask_acc_d;
      bit3_q     <= bit3_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
    end
  end

endmodule

// File: doc/spec_mux_probe.md
SPEC_MUX_PROBE -- requirements
Module: spec_mux_probe

Interface
REQ-001 SHALL provide parameter SETTLE, default 1: cycles each select value is held before sampling; legal range 1..15.
REQ-002 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request one sweep; sampled only in IDLE.
REQ-005 SHALL provide port sel_out  output  3  select driven to the external 4-input special mux.
REQ-006 SHALL provide port mux_out  input  1  mux result returned from the external mux.
REQ-007 SHALL provide port busy  output  1  high while a sweep is in progress.
REQ-008 SHALL provide port done  output  1  single-cycle pulse; results are valid.
REQ-009 SHALL provide port bit3  output  1  recovered inp[3] of the probed mux.
REQ-010 SHALL provide port err  output  1  high if any select returned an unexpected value.
REQ-011 SHALL provide port err_mask  output  8  bit s set if select s returned an unexpected value.

Function
REQ-012 SHALL implement states IDLE, SWEEP, DONE.
REQ-013 IDLE: sel_out=0, busy=0, done=0; start=1 -> SWEEP with sel_out=0 and settle counter=0.
REQ-014 SWEEP: busy=1; each select value SHALL be held for exactly SETTLE cycles; mux_out SHALL be sampled on the last cycle of that hold.
REQ-015 After sampling, sel_out SHALL increment by 1; after sampling sel=7 -> DONE, with sel_out returning to 0.
REQ-016 Expected values: sel 0,1,5 -> 0; sel 6 -> 1; sel 2,3,4,7 -> the value sampled at sel=2.
REQ-017 The sample at sel=2 SHALL become bit3; sels 0 and 1 are checked against their constants before sel=2 is reached.
REQ-018 err_mask[s] SHALL be set if the sample at sel s differs from its expected value; err SHALL be the OR of err_mask.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; bit3, err and err_mask SHALL update on entry to DONE.
REQ-020 bit3, err and err_mask SHALL hold their values from DONE until the next DONE.
REQ-021 Latency: done SHALL assert exactly 8*SETTLE+1 cycles after the clock edge that samples start.
REQ-022 start SHALL be ignored in SWEEP and DONE; start held high continuously SHALL begin a new sweep on the first IDLE cycle.
REQ-023 Partial results SHALL accumulate in internal registers and SHALL never be visible on the outputs before DONE.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, with sel_out=0, busy=0, done=0, bit3=0, err=0, err_mask=0, and all counters and partial results cleared.
REQ-025 Reset during SWEEP SHALL abandon the sweep without pulsing done; the next start SHALL perform a complete sweep from sel=0.

Structure
REQ-026 A shared package spec_mux_pkg SHALL hold the state enum, the 8-entry expected-value table (constant 0, constant 1, or follows inp[3]), and the select width constant.
REQ-027 The settle counter and the select counter SHALL be implemented inline; no sub-module is required.
REQ-028 The bench SHALL instantiate the existing spec_mux as the probed device.

Verification
REQ-029 Fault-free mux, inp=4'b1001, SETTLE=1, pulse start -> done at cycle 9; bit3=1, err=0, err_mask=8'h00.
REQ-030 Fault-free mux, inp=4'b0000 -> bit3=0, err=0, err_mask=8'h00.
REQ-031 mux_out stuck at 0 -> bit3=0, err=1, err_mask=8'b0100_0000.
REQ-032 mux_out stuck at 1 -> bit3=1, err=1, err_mask=8'b0010_0011.
REQ-033 SETTLE=3, start re-pulsed during the sweep -> a single done at cycle 25; the re-pulse has no effect.
REQ-034 rst asserted while sel_out=4 -> all outputs 0 at once and no done pulse; a following start completes with the correct results.
